ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Downstream stage of the PS/2 receiver. Consumes {scan_code, scan_code_ready} pulses (set-2
//  make codes, E0/E1 prefixes and F0; the code following F0 is already suppressed upstream).
//  Folds prefixes into key events, filters typematic repeats, maps printable keys to ASCII and
//  buffers events in a FWFT FIFO read by the game/control logic.
// PARAMETERS
//  DEPTH        8  FIFO entries; power of two, >=2
//  DROP_REPEAT  1  1: drop a make identical to last pushed event when no F0 since that push
// PORTS
//  clk              in   1   system clock (50 MHz)
//  reset            in   1   asynchronous, active-low reset
//  scan_code        in   8   byte from PS/2 receiver; valid only while scan_code_ready=1
//  scan_code_ready  in   1   single-cycle strobe, one per received byte
//  rd_en            in   1   pop head entry; ignored when key_valid=0
//  clr_overflow     in   1   clears overflow sticky flag
//  key_valid        out  1   FIFO not empty; head fields valid
//  key_ext          out  1   head event had E0 prefix
//  key_scan         out  8   head scan code (E1 for Pause)
//  key_ascii        out  8   head ASCII, 8'h00 if unmapped
//  fifo_count       out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow         out  1   sticky: an event was dropped because FIFO full
// BEHAVIOUR
//  Reset (reset=0, any cycle, mid-sequence included): FSM->IDLE, ext/skip/last-key cleared,
//   FIFO emptied; key_valid=0, key_ext=0, key_scan=0, key_ascii=0, fifo_count=0, overflow=0.
//  Only cycles with scan_code_ready=1 advance the FSM. States:
//   IDLE : E0->EXT. E1->push {0,E1,00}, skip_cnt=5, ->PAUSE. F0->clear last-key, stay.
//          other->push {0,code,ascii(code)}, stay.
//   EXT  : F0->clear last-key, ->IDLE. E0->stay EXT. E1->as IDLE-E1.
//          other->push {1,code,ascii_ext(code)}, ->IDLE.
//   PAUSE: each strobe decrements skip_cnt (drops 14 77 E1 F0 F0); at 1->0 go IDLE.
//  Repeat filter (DROP_REPEAT=1): last-key={ext,scan} of last push, plus valid bit; a candidate
//   equal to a valid last-key is dropped (no push, no overflow). F0 invalidates last-key.
//   Pause (E1) never filtered. DROP_REPEAT=0: every candidate pushed.
//  Latency: strobe in cycle N -> entry written at end of N; key_valid/fields reflect it in N+1
//   if FIFO was empty. Head fields registered/driven from storage, no comb path from scan_code.
//  FIFO: FWFT; pop at clock edge when rd_en=1 & key_valid=1. Pointers log2(DEPTH) bits, wrap
//   modulo DEPTH; count separate, full = (count==DEPTH).
//   push & pop same cycle: both occur, count unchanged, legal when full or with count=1.
//   push when full w/o pop: entry dropped, overflow<=1. pop when empty: no effect.
//   clr_overflow & new overflow same cycle: overflow stays 1 (set wins).
//  key_* hold last head value when FIFO empty is not required; bench checks fields only when
//   key_valid=1.
//  ASCII map (non-ext): 1C..1A letters a..z lowercase, 45/16/1E/26/25/2E/36/3D/3E/46 digits
//   0..9, 29->20, 5A->0D, 66->08, 76->1B, 0D->09; all else 00. Ext: 5A->0D (keypad Enter),
//   4A->2F; all else 00.
// STRUCTURE
//  Shared package: localparams BREAK_CODE=8'hF0, EXT_CODE=8'hE0, PAUSE_CODE=8'hE1,
//   PAUSE_SKIP=5, FSM state encodings, FIFO entry width (17 = ext+scan+ascii).
//  Sub-module ps2_ascii_lut (combinational, in: ext, scan; out: ascii). FSM, repeat filter
//   and FIFO in this module.
// TESTING
//  1 strobes 1C,F0 -> one entry {0,1C,61}; key_valid one cycle after 1C strobe; count=1.
//  2 E0 75, E0 F0, E0 5A -> entries {1,75,00},{1,5A,0D}; E0 F0 pushes nothing.
//  3 1C,1C,1C,F0,1C (DROP_REPEAT=1) -> two {0,1C,61}; DROP_REPEAT=0 -> four entries.
//  4 E1 14 77 E1 F0 F0 then 29 -> entries {0,E1,00},{0,29,20}; no spurious 14/77.
//  5 DEPTH+2 distinct makes, no reads -> count=DEPTH, overflow=1, head = first code;
//    push+rd_en same cycle at full -> count stays DEPTH; clr_overflow -> 0.
//  6 reset=0 while in EXT with 3 entries -> all outputs 0; next 1C yields {0,1C,61}, ext=0.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder_pkg
// Shared definitions for the PS/2 key decoder: protocol byte values, the
// number of bytes swallowed after a Pause prefix, decoder FSM states and the
// FIFO entry layout {ext, scan, ascii}.
// ----------------------------------------------------------------------------
package ps2_key_decoder_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] PAUSE_CODE = 8'hE1;

    // Pause make is E1 14 77 E1 F0 F0 (bytes after the first E1 are dropped)
    localparam int PAUSE_SKIP = 5;

    localparam int ENTRY_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXT   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] scan;
        logic [7:0] ascii;
    } entry_t;

endpackage

// File: rtl/ps2_key_decoder_ascii_lut.sv
// ----------------------------------------------------------------------------
// ps2_ascii_lut
// Combinational set-2 scan code to ASCII map. Unmapped codes give 8'h00.
// Ports:
//   ext_i   : code carried an E0 prefix
//   scan_i  : set-2 make code
//   ascii_o : ASCII character, 8'h00 if unmapped
// ----------------------------------------------------------------------------
module ps2_ascii_lut (
    input  logic       ext_i,
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);
    always_comb begin
        ascii_o = 8'h00;
        if (ext_i) begin
            case (scan_i)
                8'h5A:   ascii_o = 8'h0D;   // keypad Enter
                8'h4A:   ascii_o = 8'h2F;   // keypad '/'
                default: ascii_o = 8'h00;
            endcase
        end else begin
            case (scan_i)
                8'h1C: ascii_o = 8'h61;  8'h32: ascii_o = 8'h62;
                8'h21: ascii_o = 8'h63;  8'h23: ascii_o = 8'h64;
                8'h24: ascii_o = 8'h65;  8'h2B: ascii_o = 8'h66;
                8'h34: ascii_o = 8'h67;  8'h33: ascii_o = 8'h68;
                8'h43: ascii_o = 8'h69;  8'h3B: ascii_o = 8'h6A;
                8'h42: ascii_o = 8'h6B;  8'h4B: ascii_o = 8'h6C;
                8'h3A: ascii_o = 8'h6D;  8'h31: ascii_o = 8'h6E;
                8'h44: ascii_o = 8'h6F;  8'h4D: ascii_o = 8'h70;
                8'h15: ascii_o = 8'h71;  8'h2D: ascii_o = 8'h72;
                8'h1B: ascii_o = 8'h73;  8'h2C: ascii_o = 8'h74;
                8'h3C: ascii_o = 8'h75;  8'h2A: ascii_o = 8'h76;
                8'h1D: ascii_o = 8'h77;  8'h22: ascii_o = 8'h78;
                8'h35: ascii_o = 8'h79;  8'h1A: ascii_o = 8'h7A;
                8'h45: ascii_o = 8'h30;  8'h16: ascii_o = 8'h31;
                8'h1E: ascii_o = 8'h32;  8'h26: ascii_o = 8'h33;
                8'h25: ascii_o = 8'h34;  8'h2E: ascii_o = 8'h35;
                8'h36: ascii_o = 8'h36;  8'h3D: ascii_o = 8'h37;
                8'h3E: ascii_o = 8'h38;  8'h46: ascii_o = 8'h39;
                8'h29: ascii_o = 8'h20;  8'h5A: ascii_o = 8'h0D;
                8'h66: ascii_o = 8'h08;  8'h76: ascii_o = 8'h1B;
                8'h0D: ascii_o = 8'h09;
                default: ascii_o = 8'h00;
            endcase
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
// Folds E0/E1/F0 prefixes from the PS/2 byte stream into key events, drops
// typematic repeats, attaches ASCII and queues events in a FWFT FIFO.
// Ports:
//   clk, reset (async, active low)
//   scan_code/scan_code_ready : byte strobe from the PS/2 receiver
//   rd_en                     : pop head entry (ignored when empty)
//   clr_overflow              : clear the sticky overflow flag
//   key_valid/key_ext/key_scan/key_ascii : FIFO head event
//   fifo_count                : entries held, 0..DEPTH
//   overflow                  : sticky, an event was lost to a full FIFO
// ----------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter bit DROP_REPEAT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               scan_code,
    input  logic                     scan_code_ready,
    input  logic                     rd_en,
    input  logic                     clr_overflow,
    output logic                     key_valid,
    output logic                     key_ext,
    output logic [7:0]               key_scan,
    output logic [7:0]               key_ascii,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_e      state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic        last_vld_q, last_vld_d;
    logic [8:0]  last_key_q, last_key_d;

    logic        cand_vld, cand_ext, cand_pause, is_rep, push_req;
    logic [7:0]  cand_ascii;
    entry_t      wr_entry, head;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q;
    logic               full, do_push, do_pop, ovf_set;

    ps2_ascii_lut u_lut (
        .ext_i   (cand_ext),
        .scan_i  (scan_code),
        .ascii_o (cand_ascii)
    );

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        last_vld_d = last_vld_q;
        last_key_d = last_key_q;
        cand_vld   = 1'b0;
        cand_ext   = 1'b0;
        cand_pause = 1'b0;
        if (scan_code_ready) begin
            case (state_q)
                ST_IDLE, ST_EXT: begin
                    if (scan_code == EXT_CODE) begin
                        state_d = ST_EXT;
                    end else if (scan_code == PAUSE_CODE) begin
                        cand_vld   = 1'b1;
                        cand_pause = 1'b1;
                        skip_d     = 3'(PAUSE_SKIP);
                        state_d    = ST_PAUSE;
                    end else if (scan_code == BREAK_CODE) begin
                        // release seen: the next make of the same key is a new press
                        last_vld_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cand_vld = 1'b1;
                        cand_ext = (state_q == ST_EXT);
                        state_d  = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        is_rep   = DROP_REPEAT && !cand_pause && last_vld_q &&
                   (last_key_q == {cand_ext, scan_code});
        push_req = cand_vld && !is_rep;
        if (push_req) begin
            last_vld_d = 1'b1;
            last_key_d = {cand_ext, scan_code};
        end
    end

    assign wr_entry = '{ext: cand_ext, scan: scan_code, ascii: cand_ascii};

    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = rd_en && (count_q != '0);
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && full && !do_pop;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            last_vld_q <= 1'b0;
            last_key_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            last_vld_q <= last_vld_d;
            last_key_q <= last_key_d;
            count_q    <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (ovf_set)           overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    // Storage needs no reset: head fields are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head       = mem_q[rd_ptr_q];
    assign key_valid  = (count_q != '0);
    assign key_ext    = key_valid ? head.ext   : 1'b0;
    assign key_scan   = key_valid ? head.scan  : 8'h00;
    assign key_ascii  = key_valid ? head.ascii : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
